// File: rtl/digit_scan_ctrl_pkg.sv
// digit_scan_ctrl_pkg: shared state encoding and constants for the digit scanner
package digit_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;
  localparam int DIGIT_W = 4;
  localparam logic [7:0] ALL_OFF = 8'hFF;
endpackage

// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: digit/enable bundle between timekeeping, scanner and display pins
// SCAN_BRIGHTNESS_EN adds the 3-bit bright signal.
interface digit_scan_ctrl_if import digit_scan_ctrl_pkg::*; #(
  parameter int NUM_DIGITS = 6
) ();
  logic en;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0] blank_mask;
`ifdef SCAN_BRIGHTNESS_EN
  logic [2:0] bright;
`endif
  logic [DIGIT_W-1:0] dec_digit;
  logic [NUM_DIGITS-1:0] digit_en_n;
  logic frame_start;
  logic [2:0] slot_idx;
`ifdef SCAN_BRIGHTNESS_EN
  modport master (output en, digits_in, blank_mask, bright,
                  input dec_digit, digit_en_n, frame_start, slot_idx);
  modport slave (input en, digits_in, blank_mask, bright,
                 output dec_digit, digit_en_n, frame_start, slot_idx);
`else
  modport master (output en, digits_in, blank_mask,
                  input dec_digit, digit_en_n, frame_start, slot_idx);
  modport slave (input en, digits_in, blank_mask,
                 output dec_digit, digit_en_n, frame_start, slot_idx);
`endif
endinterface

// File: rtl/digit_scan_ctrl_scan_phase_cnt.sv
// scan_phase_cnt: loadable down-counter timing BLANK and DRIVE phases; done while count is zero
module scan_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt_d,
  output logic         done
);
  logic [W-1:0] cnt_q;
  assign done = cnt_q == '0;
  always_comb cnt_d = clr ? '0 : load ? load_val : done ? cnt_q : cnt_q - W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 7-segment scanner with per-frame snapshot and blanking guard
// Define SCAN_BRIGHTNESS_EN to add the bright input (PWM of the enable within each DRIVE slot).
module digit_scan_ctrl import digit_scan_ctrl_pkg::*; #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input logic clk,
  input logic rst_n,
  digit_scan_ctrl_if.slave io
);
  localparam int CW = $clog2(SCAN_DIV > GUARD_CYCLES ? SCAN_DIV : GUARD_CYCLES);
  localparam logic [NUM_DIGITS-1:0] OFF = ALL_OFF[NUM_DIGITS-1:0];
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LD = CW'(SCAN_DIV - 1);
  state_e state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] snap_q, snap_d;
  logic fs_q, fs_d;
  logic [DIGIT_W-1:0] dec_q, dec_d;
  logic [NUM_DIGITS-1:0] en_n_q, en_n_d, sel;
  logic load, done, dim_ok, wrap;
  logic [CW-1:0] load_val, cnt_d;
  logic [31:0] on_len;
  scan_phase_cnt #(.W(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!io.en), .load(load),
    .load_val(load_val), .cnt_d(cnt_d), .done(done)
  );
  // On-time within DRIVE measured from the first DRIVE cycle; the default build lights the whole slot.
`ifdef SCAN_BRIGHTNESS_EN
  assign on_len = ((32'(io.bright) + 32'd1) * 32'(SCAN_DIV)) >> 3;
`else
  assign on_len = 32'(SCAN_DIV);
`endif
  assign dim_ok = 32'(DRIVE_LD) - 32'(cnt_d) < on_len;
  assign wrap = slot_q == LAST;
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    snap_d = snap_q;
    fs_d = 1'b0;
    load = 1'b0;
    load_val = GUARD_LD;
    if (!io.en) begin
      state_d = IDLE;
      slot_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          slot_d = '0;
          snap_d = io.digits_in;
          fs_d = 1'b1;
          load = 1'b1;
        end
        BLANK: if (done) begin
          state_d = DRIVE;
          load = 1'b1;
          load_val = DRIVE_LD;
        end
        DRIVE: if (done) begin
          state_d = BLANK;
          load = 1'b1;
          fs_d = wrap;
          slot_d = wrap ? 3'd0 : slot_q + 3'd1;
          snap_d = wrap ? io.digits_in : snap_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Outputs are computed from next-state values so the registered pins line up with the state.
  always_comb begin
    sel = NUM_DIGITS'(1) << slot_d;
    dec_d = state_d == IDLE ? '0 : DIGIT_W'(snap_d >> (slot_d * DIGIT_W));
    en_n_d = (state_d == DRIVE && !(|(io.blank_mask & sel)) && dim_ok) ? ~sel : OFF;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q <= '0;
      snap_q <= '0;
      fs_q <= 1'b0;
      dec_q <= '0;
      en_n_q <= OFF;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      snap_q <= snap_d;
      fs_q <= fs_d;
      dec_q <= dec_d;
      en_n_q <= en_n_d;
    end
  end
  assign io.dec_digit = dec_q;
  assign io.digit_en_n = en_n_q;
  assign io.frame_start = fs_q;
  assign io.slot_idx = slot_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed self-checking bench for digit_scan_ctrl (6 digits, guard 1)
module tb_digit_scan_ctrl;
  import digit_scan_ctrl_pkg::*;
`ifdef SCAN_BRIGHTNESS_EN
  localparam int SD = 8;
  localparam logic [2:0] B_LOW = 3'd1;
`else
  localparam int SD = 4;
  localparam logic [2:0] B_LOW = 3'd7;
`endif
  localparam int SLOT = SD + 1;
  localparam int FRAME = 6 * SLOT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int failed = 0;
  int total = 0;
  digit_scan_ctrl_if #(.NUM_DIGITS(6)) io ();
  digit_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(SD), .GUARD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .io(io.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  // Called at the negedge where frame_start is high; walks one whole frame cycle by cycle.
  task automatic frame(input logic [23:0] snap, input logic [5:0] mask, input logic [2:0] brt,
                       input int chg_t, input logic [23:0] chg_val);
    int s, p, on_len;
    logic [5:0] want_en;
    logic [3:0] want_dec;
    io.blank_mask = mask;
`ifdef SCAN_BRIGHTNESS_EN
    io.bright = brt;
`endif
    on_len = ((int'(brt) + 1) * SD) >> 3;
    for (int t = 0; t < FRAME; t++) begin
      s = t / SLOT;
      p = t % SLOT;
      want_en = (p == 0 || mask[s] || p - 1 >= on_len) ? 6'h3F : ~(6'd1 << s);
      want_dec = snap[4*s +: 4];
      chk("frame_start", 32'(io.frame_start), 32'(t == 0));
      chk("slot_idx", 32'(io.slot_idx), 32'(s));
      chk("dec_digit", 32'(io.dec_digit), 32'(want_dec));
      chk("digit_en_n", 32'(io.digit_en_n), 32'(want_en));
      if (t == chg_t) io.digits_in = chg_val;
      @(negedge clk);
    end
  endtask
  initial begin
    io.en = 1'b0;
    io.digits_in = 24'h123456;
    io.blank_mask = 6'h00;
`ifdef SCAN_BRIGHTNESS_EN
    io.bright = 3'd7;
`endif
    repeat (2) @(negedge clk);
    chk("rst_en_n", 32'(io.digit_en_n), 32'h3F);
    chk("rst_dec", 32'(io.dec_digit), 32'h0);
    chk("rst_fs", 32'(io.frame_start), 32'h0);
    chk("rst_slot", 32'(io.slot_idx), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_en_n", 32'(io.digit_en_n), 32'h3F);
    chk("idle_fs", 32'(io.frame_start), 32'h0);
    io.en = 1'b1;
    @(negedge clk);
    frame(24'h123456, 6'h00, 3'd7, 11, 24'h999999);
    frame(24'h999999, 6'h01, 3'd7, 5, 24'hABCDEF);
    frame(24'hABCDEF, 6'h00, B_LOW, -1, 24'h0);
    repeat (3 * SLOT + 2) @(negedge clk);
    chk("drop_pre_slot", 32'(io.slot_idx), 32'd3);
    chk("drop_pre_en_n", 32'(io.digit_en_n), 32'h37);
    io.en = 1'b0;
    @(negedge clk);
    chk("drop_en_n", 32'(io.digit_en_n), 32'h3F);
    chk("drop_state", 32'(dut.state_q), 32'(IDLE));
    chk("drop_slot", 32'(io.slot_idx), 32'h0);
    chk("drop_fs", 32'(io.frame_start), 32'h0);
    repeat (3) @(negedge clk);
    chk("idle_hold_en_n", 32'(io.digit_en_n), 32'h3F);
    chk("idle_hold_fs", 32'(io.frame_start), 32'h0);
    io.en = 1'b1;
    @(negedge clk);
    frame(24'hABCDEF, 6'h00, 3'd7, -1, 24'h0);
    repeat (2) @(negedge clk);
    chk("pre_rst_en_n", 32'(io.digit_en_n), 32'h3E);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en_n", 32'(io.digit_en_n), 32'h3F);
    chk("async_state", 32'(dut.state_q), 32'(IDLE));
    chk("async_dec", 32'(io.dec_digit), 32'h0);
    io.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_en_n", 32'(io.digit_en_n), 32'h3F);
    chk("post_rst_dec", 32'(io.dec_digit), 32'h0);
    chk("post_rst_slot", 32'(io.slot_idx), 32'h0);
    chk("post_rst_fs", 32'(io.frame_start), 32'h0);
    io.en = 1'b1;
    @(negedge clk);
    frame(24'hABCDEF, 6'h00, 3'd7, -1, 24'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Time-multiplexing scan controller for the clock's multi-digit 7-segment display. Steps through NUM_DIGITS digit slots and presents each digit's 4-bit code to the shared hex-to-7-segment decoder while driving that digit's active-low common line. Captures a tear-free snapshot of the time digits once per frame and inserts a blanking guard before each slot to prevent ghosting. Sits between the timekeeping counters and the display pins.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (HH:MM:SS); legal range 2..8
SCAN_DIV, 50000, clock cycles per slot DRIVE phase; must be >= 2
GUARD_CYCLES, 8, clock cycles of all-digits-off BLANK phase before each DRIVE; must be >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; low forces display dark and returns to IDLE
digits_in  input  4*NUM_DIGITS  packed digit codes; nibble i (bits 4i+3:4i) is digit i, digit 0 = leftmost
blank_mask  input  NUM_DIGITS  bit i = 1 keeps digit i dark; its slot time is still consumed
dec_digit  output  4  code presented to the shared 7-segment decoder
digit_en_n  output  NUM_DIGITS  active-low digit common enables; at most one low at any time
frame_start  output  1  one-cycle pulse on the cycle the snapshot is captured
slot_idx  output  3  current slot index (debug/observability)

Behaviour:
- Interface fixed: single clock clk; rst_n asynchronous, active-low.
- Reset values: state IDLE, slot_idx 0, dec_digit 4'h0, digit_en_n all ones, frame_start 0, snapshot 0, all counters 0.
- States: IDLE, BLANK, DRIVE. All outputs registered.
- IDLE: digit_en_n all ones. When en=1: capture snapshot <= digits_in, pulse frame_start, slot_idx <= 0, go to BLANK.
- BLANK: digit_en_n all ones; dec_digit = snapshot nibble slot_idx (decoder settles before drive). Lasts exactly GUARD_CYCLES cycles, then DRIVE.
- DRIVE: digit_en_n[slot_idx] = 0 unless blank_mask[slot_idx] = 1 (sampled every cycle). Lasts exactly SCAN_DIV cycles. At end: if slot_idx = NUM_DIGITS-1, wrap to 0, recapture snapshot, pulse frame_start; else increment. Go to BLANK.
- Frame period = NUM_DIGITS*(GUARD_CYCLES+SCAN_DIV) cycles.
- digits_in changes mid-frame do not affect the display until the next capture.
- en=0 in any state: next cycle IDLE, all enables off, counters cleared, no frame_start. Re-enable starts a fresh frame at slot 0.
- Async reset mid-DRIVE: enables go high immediately (asynchronously).
- Codes 0xA..0xF pass through unmodified; the decoder handles them.

Optional Feature:
Macro SCAN_BRIGHTNESS_EN. When defined: extra input port bright (3 bits). Within DRIVE, the digit enable is asserted only while the phase counter is < ((bright+1)*SCAN_DIV)>>3, and off for the rest of the slot. bright=7 gives full on-time. Slot timing is unchanged. When undefined: no bright port; enable is asserted for the full DRIVE phase.

Decomposition:
- Shared package holds: state encoding (IDLE/BLANK/DRIVE), the DIGIT_W=4 constant, and the all-off enable constant.
- One natural sub-module, scan_phase_cnt: a loadable down-counter that produces the phase-done strobe for both BLANK and DRIVE lengths.
- The 7-segment decoder stays external and is driven by dec_digit.

Test Plan:
All tests use NUM_DIGITS=6, SCAN_DIV=4, GUARD_CYCLES=1.
1. Reset then en=1, digits_in=0x123456 -> frame_start 1 cycle after en; then digit_en_n 6'b111111 for 1 cycle and 6'b111110 for 4 cycles with dec_digit=6; slots 1..5 follow with codes 5,4,3,2,1; frame period 30 cycles.
2. Change digits_in to 0x999999 mid-frame -> remaining slots still show the old snapshot; new values appear only after the next frame_start.
3. blank_mask=6'b000001 -> slot 0 digit_en_n stays all ones for its full DRIVE; slot timing unchanged; other digits normal.
4. Drop en during slot 3 DRIVE -> next cycle digit_en_n all ones, state IDLE; on re-enable, frame_start fires and scanning restarts at slot 0.
5. Assert rst_n=0 asynchronously mid-DRIVE -> digit_en_n all ones before the next clk edge; after release, outputs are at reset values.
6. With SCAN_BRIGHTNESS_EN, SCAN_DIV=8, bright=1 -> enable low for 2 of 8 DRIVE cycles; bright=7 -> low for all 8; frame period unchanged.
